gen_2s_pipe: RTL

- Parametrised, pipelined successor to the team's combinational two's-complement magnitude stage in the convolution datapath.
- Takes CHANNELS signed products in one beat, e.g. the 3x3 kernel products feeding the adder tree.
- Applies a per-beat conversion mode: pass, absolute value, two's-complement to sign-magnitude, or sign-magnitude to two's-complement.
- Saturates the most-negative value, flags overflow per lane, and moves data through a two-stage valid/ready pipeline with backpressure.

---
 rtl/gen_2s_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gen_2s_pipe.sv
// gen_2s_pipe: two-stage valid/ready pipeline that converts CHANNELS signed
// lanes between two's-complement and sign-magnitude forms (or takes the
// absolute value). The most-negative value saturates and raises a per-lane
// overflow flag, and a sticky counter tracks how many lanes saturated.
module gen_2s_pipe #(
   parameter int MANT_SIZE = 10,
   parameter int WIDTH     = 2*MANT_SIZE+1,
   parameter int CHANNELS  = 9,
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*WIDTH-1:0]    in_data,
   input  logic [1:0]                   mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*WIDTH-1:0]    out_data,
   output logic [CHANNELS-1:0]          out_ovf,
   output logic [CNT_WIDTH-1:0]         sat_count
);

   localparam int POP_W = $clog2(CHANNELS+1);

   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAXP_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_ABS   = 2'b01,
      MODE_TC2SM = 2'b10,
      MODE_SM2TC = 2'b11
   } mode_t;

   logic                        rdy_armed;
   logic                        s1_valid;
   logic [CHANNELS*WIDTH-1:0]   s1_data;
   mode_t                       s1_mode;

   logic                        s2_free;
   logic                        s1_adv;
   logic                        in_fire;

   logic [CHANNELS*WIDTH-1:0]   conv_data;
   logic [CHANNELS-1:0]         conv_ovf;
   logic [POP_W-1:0]            conv_pop;

   logic [WIDTH-1:0]            lane_x;
   logic [WIDTH-1:0]            lane_neg;
   logic [WIDTH-1:0]            lane_y;
   logic                        lane_o;

   logic [CNT_WIDTH:0]          sat_sum;
   logic [CNT_WIDTH-1:0]        sat_next;

   // Output stage can take a new beat when it is empty or being drained;
   // in_ready follows out_ready combinationally so full flow has no bubble.
   assign s2_free  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = rdy_armed && (!s1_valid || s2_free);
   assign in_fire  = in_valid && in_ready;

   // Hold in_ready low until the first clock edge after reset is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_armed <= 1'b0;
      end else begin
         rdy_armed <= 1'b1;
      end
   end

   // Stage 1 captures the raw lanes and the beat's mode on each handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_mode  <= MODE_PASS;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_mode  <= mode_t'(mode);
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Per-lane conversion of the stage-1 beat, plus a popcount of saturations.
   always_comb begin
      conv_data = '0;
      conv_ovf  = '0;
      conv_pop  = '0;
      lane_x    = '0;
      lane_neg  = '0;
      lane_y    = '0;
      lane_o    = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         lane_x   = s1_data[k*WIDTH +: WIDTH];
         lane_neg = ~lane_x + ONE;
         lane_y   = lane_x;
         lane_o   = 1'b0;
         case (s1_mode)
            MODE_PASS: begin
               lane_y = lane_x;
            end
            MODE_ABS: begin
               if (lane_x == MIN_VAL) begin
                  lane_y = MAXP_VAL;
                  lane_o = 1'b1;
               end else if (lane_x[WIDTH-1]) begin
                  lane_y = lane_neg;
               end
            end
            MODE_TC2SM: begin
               if (lane_x == MIN_VAL) begin
                  lane_y = ALL_ONES;
                  lane_o = 1'b1;
               end else if (lane_x[WIDTH-1]) begin
                  lane_y = {1'b1, lane_neg[WIDTH-2:0]};
               end
            end
            MODE_SM2TC: begin
               if (lane_x[WIDTH-1]) begin
                  if (lane_x[WIDTH-2:0] == '0) begin
                     lane_y = '0;
                  end else begin
                     lane_y = ~{1'b0, lane_x[WIDTH-2:0]} + ONE;
                  end
               end
            end
            default: begin
               lane_y = lane_x;
            end
         endcase
         conv_data[k*WIDTH +: WIDTH] = lane_y;
         conv_ovf[k]                 = lane_o;
         conv_pop                    = conv_pop + {{(POP_W-1){1'b0}}, lane_o};
      end
   end

   // Saturating accumulation of the saturation events carried by this beat.
   always_comb begin
      sat_sum  = {1'b0, sat_count} + {{(CNT_WIDTH+1-POP_W){1'b0}}, conv_pop};
      sat_next = sat_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sat_sum[CNT_WIDTH-1:0];
   end

   // Stage 2 registers the converted beat; it holds while downstream stalls
   // and the counter only moves on a real stage-1 to stage-2 transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= '0;
         sat_count <= '0;
      end else if (s2_free) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= conv_data;
            out_ovf   <= conv_ovf;
            sat_count <= sat_next;
         end
      end
   end

endmodule
